// File: rtl/traffic_controller_timed.sv
// Timed, demand-actuated 4-way traffic light controller (A = NORTH+WEST, B = EAST+SOUTH).
// Optional night/fault flash state is built only when TLC_FLASH_EN is defined.
module traffic_controller_timed #(
  parameter int GREEN_A_MIN = 8,
  parameter int GREEN_B     = 6,
  parameter int YELLOW      = 3,
  parameter int ALLRED      = 2,
  parameter int FLASH_HALF  = 4,
  parameter int CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sensor_b,
  input  logic       ped_req,
  input  logic       flash_mode,
  output logic [2:0] light_NORTH,
  output logic [2:0] light_EAST,
  output logic [2:0] light_WEST,
  output logic [2:0] light_SOUTH,
  output logic       ped_walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    A_GRN = 3'd0,
    A_YEL = 3'd1,
    AR_1  = 3'd2,
    B_GRN = 3'd3,
    B_YEL = 3'd4,
    AR_2  = 3'd5,
    FLASH = 3'd6
  } state_t;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  localparam longint MAX_TMR = (longint'(1) << CNT_W) - 1;

  if (GREEN_A_MIN < 1 || GREEN_B < 1 || YELLOW < 1 || ALLRED < 1 || FLASH_HALF < 1 ||
      longint'(GREEN_A_MIN - 1) > MAX_TMR || longint'(GREEN_B - 1) > MAX_TMR ||
      longint'(YELLOW - 1) > MAX_TMR || longint'(ALLRED - 1) > MAX_TMR ||
      longint'(FLASH_HALF - 1) > MAX_TMR) begin : g_bad_params
    $error("traffic_controller_timed: durations must be >=1 and duration-1 must fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] L_GA = CNT_W'(GREEN_A_MIN - 1);
  localparam logic [CNT_W-1:0] L_GB = CNT_W'(GREEN_B - 1);
  localparam logic [CNT_W-1:0] L_Y  = CNT_W'(YELLOW - 1);
  localparam logic [CNT_W-1:0] L_AR = CNT_W'(ALLRED - 1);
  localparam logic [CNT_W-1:0] L_FH = CNT_W'(FLASH_HALF - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_tmr;
  logic [CNT_W-1:0] w_tmr_nxt;
  logic             r_demand_b;
  logic             r_ped_lat;
  logic             r_ped_walk;
  logic             w_tmr_zero;
  logic             w_enter_bgrn;
  logic             w_flash_req;
  logic             w_flash_reload;
  logic [2:0]       w_light_a;
  logic [2:0]       w_light_b;

  function automatic logic [CNT_W-1:0] dur_m1(input state_t s);
    case (s)
      A_GRN:        return L_GA;
      A_YEL, B_YEL: return L_Y;
      B_GRN:        return L_GB;
      FLASH:        return L_FH;
      default:      return L_AR;
    endcase
  endfunction

`ifdef TLC_FLASH_EN
  assign w_flash_req = flash_mode;
`else
  logic w_unused_flash_mode;
  assign w_unused_flash_mode = flash_mode;
  assign w_flash_req         = 1'b0;
`endif

  assign w_tmr_zero   = (r_tmr == '0);
  assign w_enter_bgrn = (w_state_nxt == B_GRN) && (r_state != B_GRN);

  // NOTE: every output of a combinational block is given a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_flash_reload = 1'b0;
    case (r_state)
      A_GRN: if (w_tmr_zero && r_demand_b) w_state_nxt = A_YEL;
      A_YEL: if (w_tmr_zero) w_state_nxt = AR_1;
      AR_1:  if (w_tmr_zero) w_state_nxt = w_flash_req ? FLASH : B_GRN;
      B_GRN: if (w_tmr_zero) w_state_nxt = B_YEL;
      B_YEL: if (w_tmr_zero) w_state_nxt = AR_2;
      AR_2:  if (w_tmr_zero) w_state_nxt = w_flash_req ? FLASH : A_GRN;
`ifdef TLC_FLASH_EN
      FLASH: begin
        if (w_tmr_zero) begin
          if (flash_mode) w_flash_reload = 1'b1;
          else            w_state_nxt    = AR_2;
        end
      end
`endif
      default: w_state_nxt = AR_2;
    endcase
  end

  // The timer reloads on any state change and on every flash half-period; it parks at 0
  // while A green rests waiting for demand.
  always_comb begin
    w_tmr_nxt = r_tmr;
    if (w_state_nxt != r_state) w_tmr_nxt = dur_m1(w_state_nxt);
    else if (w_flash_reload)    w_tmr_nxt = L_FH;
    else if (!w_tmr_zero)       w_tmr_nxt = r_tmr - CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the values from before the clock edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= AR_2;
      r_tmr      <= L_AR;
      r_demand_b <= 1'b0;
      r_ped_lat  <= 1'b0;
      r_ped_walk <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tmr      <= w_tmr_nxt;
      r_demand_b <= w_enter_bgrn ? 1'b0 : (r_demand_b | sensor_b | ped_req);
      r_ped_lat  <= w_enter_bgrn ? 1'b0 : (r_ped_lat | ped_req);
      r_ped_walk <= w_enter_bgrn ? r_ped_lat : (r_ped_walk && (w_state_nxt == B_GRN));
    end
  end

`ifdef TLC_FLASH_EN
  localparam logic [2:0] DARK = 3'b000;
  logic r_flash_dark;

  always_ff @(posedge clk) begin
    if (reset)                                          r_flash_dark <= 1'b0;
    else if (w_state_nxt == FLASH && r_state != FLASH)  r_flash_dark <= 1'b0;
    else if (w_flash_reload)                            r_flash_dark <= ~r_flash_dark;
  end
`endif

  always_comb begin
    w_light_a = RED;
    w_light_b = RED;
    case (r_state)
      A_GRN: w_light_a = GRN;
      A_YEL: w_light_a = YEL;
      B_GRN: w_light_b = GRN;
      B_YEL: w_light_b = YEL;
`ifdef TLC_FLASH_EN
      FLASH: begin
        w_light_a = r_flash_dark ? DARK : YEL;
        w_light_b = r_flash_dark ? DARK : RED;
      end
`endif
      default: ;
    endcase
  end

  assign light_NORTH = w_light_a;
  assign light_WEST  = w_light_a;
  assign light_EAST  = w_light_b;
  assign light_SOUTH = w_light_b;
  assign ped_walk    = r_ped_walk;
  assign phase       = r_state;

endmodule
